// File: rtl/wave_pkg.sv
// wave_pkg: shared FSM states and display/sample constants for the wave_* modules
package wave_pkg;
  localparam int SAMPLE_W = 12;
  localparam int OLED_W = 96;
  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POST, HOLD} wave_state_t;
endpackage

// File: rtl/wave_sample_ram.sv
// wave_sample_ram: 2*DEPTH x DW simple dual-port RAM, address {bank,idx}, registered read
//   clk      clock
//   i_we     write enable
//   i_waddr  write address {bank,idx}
//   i_wdata  write data
//   i_raddr  read address {bank,idx}
//   o_rdata  read data, one cycle after i_raddr
module wave_sample_ram
  import wave_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int DEPTH = OLED_W,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2][DEPTH];
  logic [DW-1:0] r_q;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr[AW]][i_waddr[AW-1:0]] <= i_wdata;
    r_q <= r_mem[i_raddr[AW]][i_raddr[AW-1:0]];
  end
  assign o_rdata = r_q;
endmodule

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: triggered ping-pong waveform capture with display column read-out
//   clk, rst_n      clock, asynchronous active-low reset
//   i_sample_tick   one-cycle strobe per audio sample
//   i_mic_in        mic sample, valid with i_sample_tick
//   i_pause         freeze capture; reads continue
//   i_trig_en       level trigger enable (0 = free-run)
//   i_trig_level    rising-edge trigger threshold
//   i_rd_x          display column to read
//   o_rd_data       column sample, 1-cycle latency, 0 when blank or past the frame
//   o_frame_valid   a complete frame has been swapped to the front
//   o_trig_auto     front frame came from the timeout
//   o_frame_cnt     completed-frame counter
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int DEPTH = OLED_W,
  parameter int PRE = 32,
  parameter int AUTO_TIMEOUT = 2000,
  parameter int HOLD_TICKS = 400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sample_tick,
  input  logic [DW-1:0] i_mic_in,
  input  logic          i_pause,
  input  logic          i_trig_en,
  input  logic [DW-1:0] i_trig_level,
  input  logic [6:0]    i_rd_x,
  output logic [DW-1:0] o_rd_data,
  output logic          o_frame_valid,
  output logic          o_trig_auto,
  output logic [7:0]    o_frame_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(AUTO_TIMEOUT + HOLD_TICKS + DEPTH + 1);
  wave_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [AW-1:0] r_wr_ptr, r_trig_ptr, w_trig_ptr_n, r_start, w_start_n, w_ptr_inc, w_idx;
  logic [AW:0] w_sum;
  logic [DW-1:0] r_prev, w_ram_q;
  logic [7:0] r_frame_cnt;
  logic r_front, r_auto_flag, w_auto_flag_n, r_trig_auto, r_frame_valid, r_rd_ok;
  logic w_q, w_wr, w_trig, w_swap;
  assign w_q = i_sample_tick & ~i_pause;
  assign w_wr = w_q && (r_state != HOLD);
  assign w_trig = i_trig_en ? (r_prev < i_trig_level && i_mic_in >= i_trig_level) : 1'b1;
  assign w_ptr_inc = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_start_n = (w_trig_ptr_n >= AW'(PRE)) ? w_trig_ptr_n - AW'(PRE) : w_trig_ptr_n + AW'(DEPTH - PRE);
  assign w_sum = (AW+1)'(r_start) + (AW+1)'(i_rd_x);
  assign w_idx = AW'((w_sum >= (AW+1)'(DEPTH)) ? w_sum - (AW+1)'(DEPTH) : w_sum);
  // r_cnt is reused as pre-trigger, timeout, post-trigger and hold counter
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_trig_ptr_n = r_trig_ptr;
    w_auto_flag_n = r_auto_flag;
    w_swap = 1'b0;
    if (w_q) begin
      case (r_state)
        IDLE, PRETRIG: begin
          w_cnt_n = (r_state == IDLE) ? CW'(1) : w_cnt_inc;
          w_state_n = (w_cnt_n >= CW'(PRE)) ? ARMED : PRETRIG;
          if (w_cnt_n >= CW'(PRE)) w_cnt_n = '0;
        end
        ARMED: begin
          w_cnt_n = w_cnt_inc;
          if (w_trig || w_cnt_inc == CW'(AUTO_TIMEOUT)) begin
            w_trig_ptr_n = r_wr_ptr;
            w_auto_flag_n = ~w_trig;
            w_state_n = POST;
            w_cnt_n = CW'(1);
          end
        end
        POST: w_cnt_n = w_cnt_inc;
        HOLD: begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc >= CW'(HOLD_TICKS)) begin
            w_state_n = (PRE == 0) ? ARMED : PRETRIG;
            w_cnt_n = '0;
          end
        end
        default: w_state_n = IDLE;
      endcase
      // the trigger sample itself closes the frame when only one post sample is needed
      if (w_state_n == POST && w_cnt_n == CW'(DEPTH - PRE)) begin
        w_swap = 1'b1;
        w_state_n = HOLD;
        w_cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_wr_ptr <= '0;
      r_trig_ptr <= '0;
      r_auto_flag <= 1'b0;
      r_prev <= '0;
      r_front <= 1'b0;
      r_start <= '0;
      r_trig_auto <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_cnt <= '0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_trig_ptr <= w_trig_ptr_n;
      r_auto_flag <= w_auto_flag_n;
      if (w_q) r_prev <= i_mic_in;
      if (w_wr) r_wr_ptr <= w_ptr_inc;
      if (w_swap) begin
        r_front <= ~r_front;
        r_start <= w_start_n;
        r_trig_auto <= w_auto_flag_n;
        r_frame_valid <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      r_rd_ok <= r_frame_valid && ({1'b0, i_rd_x} < 8'(DEPTH));
    end
  end
  wave_sample_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .i_we(w_wr),
    .i_waddr({~r_front, r_wr_ptr}),
    .i_wdata(i_mic_in),
    .i_raddr({r_front, w_idx}),
    .o_rdata(w_ram_q)
  );
  assign o_rd_data = r_rd_ok ? w_ram_q : '0;
  assign o_frame_valid = r_frame_valid;
  assign o_trig_auto = r_trig_auto;
  assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb_wave_capture_ctrl: randomized bench for wave_capture_ctrl against a sample-queue frame model
module tb_wave_capture_ctrl;
  localparam int DW = 12, DEPTH = 96, PRE = 32, AUTO = 2000, HOLD = 400;
  localparam int M_IDLE = 0, M_FILL = 1, M_ARM = 2, M_POST = 3, M_HOLD = 4;
  logic clk = 0, rst_n = 0, i_sample_tick = 0, i_pause = 0, i_trig_en = 1;
  logic [DW-1:0] i_mic_in = '0, i_trig_level = 12'd2048;
  logic [6:0] i_rd_x = '0;
  logic [DW-1:0] o_rd_data;
  logic o_frame_valid, o_trig_auto;
  logic [7:0] o_frame_cnt;
  int n_tot = 0, n_bad = 0;
  int m_phase, m_hist[$], m_frame[DEPTH], m_armed_n, m_hold_n, m_trig_idx, m_prev, m_cnt, m_frames = 0;
  bit m_valid, m_auto, m_auto_pend, m_pub;
  int mode = 0, t = 0;

  wave_capture_ctrl #(.DW(DW), .DEPTH(DEPTH), .PRE(PRE), .AUTO_TIMEOUT(AUTO), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .i_sample_tick(i_sample_tick), .i_mic_in(i_mic_in), .i_pause(i_pause),
    .i_trig_en(i_trig_en), .i_trig_level(i_trig_level), .i_rd_x(i_rd_x), .o_rd_data(o_rd_data),
    .o_frame_valid(o_frame_valid), .o_trig_auto(o_trig_auto), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = M_IDLE;
    m_hist.delete();
    foreach (m_frame[k]) m_frame[k] = 0;
    m_valid = 0; m_auto = 0; m_cnt = 0; m_prev = 0; m_pub = 0; m_armed_n = 0; m_hold_n = 0;
  endtask

  // Frame = the PRE samples written before the trigger sample, the trigger sample, and what follows
  task automatic m_update(input bit q, input int s);
    bit hit;
    int lvl = int'(i_trig_level);
    if (!q) return;
    if (m_phase == M_HOLD) begin
      m_hold_n++;
      if (m_hold_n == HOLD) begin
        m_hist.delete();
        m_armed_n = 0;
        m_phase = (PRE == 0) ? M_ARM : M_FILL;
      end
    end else begin
      if (m_phase == M_IDLE) m_hist.delete();
      m_hist.push_back(s);
      if (m_phase == M_ARM) begin
        m_armed_n++;
        hit = i_trig_en ? (m_prev < lvl && s >= lvl) : 1'b1;
        if (hit || m_armed_n == AUTO) begin
          m_trig_idx = m_hist.size() - 1;
          m_auto_pend = !hit;
          m_phase = M_POST;
        end
      end else if (m_phase != M_POST) begin
        m_phase = (m_hist.size() >= PRE) ? M_ARM : M_FILL;
        m_armed_n = 0;
      end
      if (m_phase == M_POST && m_hist.size() - m_trig_idx == DEPTH - PRE) begin
        for (int k = 0; k < DEPTH; k++) m_frame[k] = m_hist[m_trig_idx - PRE + k];
        m_valid = 1;
        m_auto = m_auto_pend;
        m_cnt = (m_cnt + 1) % 256;
        m_frames++;
        m_pub = 1;
        m_phase = M_HOLD;
        m_hold_n = 0;
      end
    end
    m_prev = s;
  endtask

  function automatic int exp_rd(input int x);
    return (m_valid && x < DEPTH) ? m_frame[x] : 0;
  endfunction

  task automatic sweep();
    for (int x = 0; x < 128; x++) begin
      i_rd_x = 7'(x);
      if (x > 0) check("rd_latency", int'(o_rd_data), exp_rd(x - 1));
      @(posedge clk);
      #1;
      check($sformatf("rd[%0d]", x), int'(o_rd_data), exp_rd(x));
    end
  endtask

  task automatic check_frame();
    check("frame_valid", int'(o_frame_valid), int'(m_valid));
    check("trig_auto", int'(o_trig_auto), int'(m_auto));
    check("frame_cnt", int'(o_frame_cnt), m_cnt);
    sweep();
  endtask

  task automatic read_at(input int x, output int v);
    i_rd_x = 7'(x);
    @(posedge clk);
    #1;
    v = int'(o_rd_data);
  endtask

  task automatic step(input bit tk, input int s);
    i_sample_tick = tk;
    i_mic_in = DW'(s);
    @(posedge clk);
    m_update(tk && !i_pause, s);
    #1;
    i_sample_tick = 0;
    if (m_pub) begin
      m_pub = 0;
      check_frame();
    end
  endtask

  task automatic drive();
    int s;
    bit tk = 1;
    case (mode)
      0: s = (t * 64) % 4096;
      1: s = 100;
      3: s = (m_phase == M_ARM && m_armed_n == AUTO - 1) ? 3000 : 100;
      default: begin
        s = $urandom_range(0, 4095);
        tk = $urandom_range(0, 3) != 0;
        i_pause = $urandom_range(0, 9) == 0;
        i_trig_en = $urandom_range(0, 9) != 0;
        if ($urandom_range(0, 49) == 0) i_trig_level = DW'($urandom_range(500, 3500));
      end
    endcase
    step(tk, s);
    t++;
  endtask

  task automatic run_frame(input int limit);
    int f0 = m_frames;
    int n = 0;
    while (m_frames == f0 && n < limit) begin
      drive();
      n++;
    end
    check("frame_done", m_frames - f0, 1);
  endtask

  initial begin
    int v, n, c0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", int'(o_rd_data), 0);
    check("rst_valid", int'(o_frame_valid), 0);
    check("rst_auto", int'(o_trig_auto), 0);
    check("rst_cnt", int'(o_frame_cnt), 0);
    rst_n = 1;

    mode = 0; t = 0;
    run_frame(1000);
    read_at(32, v);
    check("ramp_trig_x32", v, 2048);
    read_at(0, v);
    check("ramp_x0", v, 0);
    check("ramp_auto", int'(o_trig_auto), 0);
    check("ramp_cnt", int'(o_frame_cnt), 1);

    mode = 1;
    run_frame(4000);
    check("const_auto", int'(o_trig_auto), 1);
    read_at(50, v);
    check("const_x50", v, 100);
    read_at(95, v);
    check("const_x95", v, 100);

    n = 0;
    while (!(m_phase == M_ARM && m_armed_n == 100) && n < 4000) begin
      drive();
      n++;
    end
    check("pause_reach_armed", m_armed_n, 100);
    c0 = m_cnt;
    i_pause = 1;
    repeat (500) drive();
    check("pause_cnt_frozen", int'(o_frame_cnt), c0);
    sweep();
    i_pause = 0;
    n = 0;
    while (int'(o_frame_cnt) == c0 && n < 3000) begin
      drive();
      n++;
    end
    check("pause_delay", n, AUTO - 100 + DEPTH - PRE - 1);
    check("pause_auto", int'(o_trig_auto), 1);

    mode = 3;
    run_frame(4000);
    check("cross_at_timeout", int'(o_trig_auto), 0);
    read_at(32, v);
    check("cross_sample", v, 3000);

    mode = 0; t = 0;
    n = 0;
    while (m_phase != M_POST && n < 3000) begin
      drive();
      n++;
    end
    check("reach_post", m_phase, M_POST);
    repeat (5) drive();
    #2;
    rst_n = 0;
    #1;
    check("arst_rd_data", int'(o_rd_data), 0);
    check("arst_valid", int'(o_frame_valid), 0);
    check("arst_auto", int'(o_trig_auto), 0);
    check("arst_cnt", int'(o_frame_cnt), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_frame();
    t = 0;
    run_frame(1000);
    check("restart_cnt", int'(o_frame_cnt), 1);

    mode = 2;
    repeat (6) run_frame(6000);
    i_pause = 0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
